// File: rtl/spi_frame_collector.sv
// -----------------------------------------------------------------------------
// spi_frame_collector
//
// Purpose:
//   Collects the bytes of one SPI chip-select frame into a small frame memory.
//   The frame is then held for a processor to read. A frame starts when cs
//   falls and ends when cs rises. Each rising edge of the shifter's ready level
//   stores one byte. Once the frame ends, the memory is frozen and frame_valid
//   is raised until the consumer pulses frame_ack. Bytes that cannot be stored
//   are dropped and reported through the sticky overflow flag. A byte cannot be
//   stored when the memory is full, or when it arrives while a frame is held.
//
// Ports:
//   clk          single clock for all logic
//   rst          synchronous, active-low reset
//   cs           SPI chip select (active low, already synchronized to clk)
//   ready        byte-complete level from the SPI slave shifter
//   data_in      received byte, stable while ready is high
//   rd_addr      processor-side read address
//   rd_data      registered read data (0 for addresses outside the frame)
//   frame_valid  a complete frame is held and readable
//   frame_len    word count of the held frame
//   frame_ack    one-cycle pulse releasing the held frame
//   overflow     sticky flag: bytes were dropped
//   ovf_count    dropped-byte counter, saturating at 255
//                (present only when SPI_FRAME_OVF_CNT_EN is defined)
//
// Configuration macro:
//   SPI_FRAME_OVF_CNT_EN  defined   : ovf_count present, overflow sticky until reset
//                         undefined : no ovf_count, overflow cleared by frame_ack
// -----------------------------------------------------------------------------
module spi_frame_collector #(
    parameter  int DATA_WIDTH = 8,
    parameter  int BUF_SIZE   = 6,
    localparam int ADDR_WIDTH = $clog2(BUF_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  frame_valid,
    output logic [ADDR_WIDTH:0]   frame_len,
    input  logic                  frame_ack,
    output logic                  overflow
`ifdef SPI_FRAME_OVF_CNT_EN
    ,
    output logic [7:0]            ovf_count
`endif
);

    localparam logic [ADDR_WIDTH:0] BUF_DEPTH = (ADDR_WIDTH + 1)'(BUF_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH:0]   wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH:0]   frame_len_reg, frame_len_next;
    logic                  frame_valid_reg, frame_valid_next;
    logic                  overflow_reg, overflow_next;
    logic                  ready_prev_reg;
    // Set once cs has been seen high. After a reset in the middle of a frame,
    // this keeps the block from joining that frame partway through.
    logic                  arm_reg, arm_next;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  wr_en;
    logic                  drop;
    logic                  ready_edge;
    logic                  rd_hit;

`ifdef SPI_FRAME_OVF_CNT_EN
    logic [7:0]            ovf_cnt_reg, ovf_cnt_next;
`endif

    // Frame memory: no reset, written only in FILL, registered read port.
    logic [DATA_WIDTH-1:0] mem [BUF_SIZE];

    assign ready_edge = ready & ~ready_prev_reg;
    assign rd_hit     = ({1'b0, rd_addr} < frame_len_reg);

    // -------------------------------------------------------------------------
    // State and control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= IDLE;
            wr_ptr_reg      <= '0;
            frame_len_reg   <= '0;
            frame_valid_reg <= 1'b0;
            overflow_reg    <= 1'b0;
            ready_prev_reg  <= 1'b0;
            arm_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wr_ptr_reg      <= wr_ptr_next;
            frame_len_reg   <= frame_len_next;
            frame_valid_reg <= frame_valid_next;
            overflow_reg    <= overflow_next;
            ready_prev_reg  <= ready;
            arm_reg         <= arm_next;
        end
    end

`ifdef SPI_FRAME_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_cnt_reg <= '0;
        end else begin
            ovf_cnt_reg <= ovf_cnt_next;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        wr_ptr_next      = wr_ptr_reg;
        frame_len_next   = frame_len_reg;
        frame_valid_next = frame_valid_reg;
        overflow_next    = overflow_reg;
        arm_next         = arm_reg | cs;
        wr_en            = 1'b0;
        drop             = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!cs && arm_reg) begin
                    wr_ptr_next = '0;
                    state_next  = FILL;
                end
            end

            FILL: begin
                if (ready_edge) begin
                    if (wr_ptr_reg < BUF_DEPTH) begin
                        wr_en       = 1'b1;
                        wr_ptr_next = wr_ptr_reg + 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                // The length uses the updated pointer, so a byte landing in
                // the same cycle as cs rising is counted in the frame.
                if (cs) begin
                    if (wr_ptr_next != '0) begin
                        frame_len_next   = wr_ptr_next;
                        frame_valid_next = 1'b1;
                        state_next       = HOLD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            HOLD: begin
                drop = ready_edge;
                if (frame_ack) begin
                    frame_valid_next = 1'b0;
                    frame_len_next   = '0;
                    arm_next         = 1'b1;
                    state_next       = IDLE;
`ifndef SPI_FRAME_OVF_CNT_EN
                    overflow_next    = 1'b0;
`endif
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // A drop in the ack cycle still counts, so it wins over the clear.
        if (drop) begin
            overflow_next = 1'b1;
        end

`ifdef SPI_FRAME_OVF_CNT_EN
        ovf_cnt_next = ovf_cnt_reg;
        if (drop && (ovf_cnt_reg != 8'hFF)) begin
            ovf_cnt_next = ovf_cnt_reg + 8'd1;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Frame memory write and registered read
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_reg <= '0;
        end else if (rd_hit) begin
            rd_data_reg <= mem[rd_addr];
        end else begin
            rd_data_reg <= '0;
        end
    end

    assign rd_data     = rd_data_reg;
    assign frame_valid = frame_valid_reg;
    assign frame_len   = frame_len_reg;
    assign overflow    = overflow_reg;
`ifdef SPI_FRAME_OVF_CNT_EN
    assign ovf_count   = ovf_cnt_reg;
`endif

endmodule

// File: tb/tb_spi_frame_collector.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_collector
//
// Directed testbench for spi_frame_collector, with DATA_WIDTH=8 and BUF_SIZE=6.
// Inputs are driven on the falling clock edge, and outputs are sampled on the
// falling clock edge. Every expected value is a hand-computed constant.
// -----------------------------------------------------------------------------
module tb_spi_frame_collector;

    localparam int DATA_WIDTH = 8;
    localparam int BUF_SIZE   = 6;
    localparam int ADDR_WIDTH = $clog2(BUF_SIZE);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cs;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data_in;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  frame_valid;
    logic [ADDR_WIDTH:0]   frame_len;
    logic                  frame_ack;
    logic                  overflow;
`ifdef SPI_FRAME_OVF_CNT_EN
    logic [7:0]            ovf_count;
`endif

    int check_count = 0;
    int error_count = 0;

    spi_frame_collector #(
        .DATA_WIDTH(DATA_WIDTH),
        .BUF_SIZE  (BUF_SIZE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cs         (cs),
        .ready      (ready),
        .data_in    (data_in),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_valid(frame_valid),
        .frame_len  (frame_len),
        .frame_ack  (frame_ack),
        .overflow   (overflow)
`ifdef SPI_FRAME_OVF_CNT_EN
        ,
        .ovf_count  (ovf_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One byte: ready high for 3 clocks, then low for 2 clocks.
    task automatic send_byte(input logic [7:0] b);
        data_in = b;
        ready   = 1'b1;
        tick(3);
        ready   = 1'b0;
        tick(2);
    endtask

    task automatic check_read(input string tag, input int addr, input logic [7:0] exp);
        rd_addr = ADDR_WIDTH'(addr);
        tick(1);
        check(tag, {24'd0, rd_data}, {24'd0, exp});
    endtask

    task automatic ack_frame();
        frame_ack = 1'b1;
        tick(1);
        frame_ack = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        cs        = 1'b1;
        ready     = 1'b0;
        data_in   = '0;
        rd_addr   = '0;
        frame_ack = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);

        // ---- reset state ----
        check("rst_valid", {31'd0, frame_valid}, 32'd0);
        check("rst_len", {28'd0, frame_len}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
`ifdef SPI_FRAME_OVF_CNT_EN
        check("rst_ovf_count", {24'd0, ovf_count}, 32'd0);
`endif

        // ---- basic frame ----
        cs = 1'b0;
        tick(2);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        cs = 1'b1;
        tick(1);
        check("basic_valid", {31'd0, frame_valid}, 32'd1);
        check("basic_len", {28'd0, frame_len}, 32'd3);
        check_read("basic_rd0", 0, 8'h11);
        check_read("basic_rd1", 1, 8'h22);
        check_read("basic_rd2", 2, 8'h33);
        check_read("basic_rd3_out", 3, 8'h00);
        check("basic_ovf", {31'd0, overflow}, 32'd0);
        ack_frame();
        check("basic_ack_valid", {31'd0, frame_valid}, 32'd0);
        tick(1);

        // ---- overflow: 8 bytes into 6 words ----
        cs = 1'b0;
        tick(2);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        cs = 1'b1;
        tick(1);
        check("ovf_valid", {31'd0, frame_valid}, 32'd1);
        check("ovf_len", {28'd0, frame_len}, 32'd6);
        for (int i = 0; i < 6; i++) check_read($sformatf("ovf_rd%0d", i), i, 8'(i + 1));
        check("ovf_flag", {31'd0, overflow}, 32'd1);
`ifdef SPI_FRAME_OVF_CNT_EN
        check("ovf_count", {24'd0, ovf_count}, 32'd2);
`endif
        ack_frame();
        check("ovf_ack_valid", {31'd0, frame_valid}, 32'd0);
`ifdef SPI_FRAME_OVF_CNT_EN
        check("ovf_after_ack", {31'd0, overflow}, 32'd1);
`else
        check("ovf_after_ack", {31'd0, overflow}, 32'd0);
`endif
        tick(1);

        // ---- empty frame ----
        cs = 1'b0;
        tick(10);
        cs = 1'b1;
        tick(3);
        check("empty_valid", {31'd0, frame_valid}, 32'd0);
        check("empty_len", {28'd0, frame_len}, 32'd0);

        // ---- hold drop ----
        cs = 1'b0;
        tick(2);
        send_byte(8'hA1);
        send_byte(8'hA2);
        cs = 1'b1;
        tick(1);
        check("hold_valid", {31'd0, frame_valid}, 32'd1);
        cs = 1'b0;              // ignored while the frame is held
        send_byte(8'hB1);
        send_byte(8'hB2);
        cs = 1'b1;
        tick(1);
        check("hold_len", {28'd0, frame_len}, 32'd2);
        check_read("hold_rd0", 0, 8'hA1);
        check_read("hold_rd1", 1, 8'hA2);
        check("hold_ovf", {31'd0, overflow}, 32'd1);
`ifdef SPI_FRAME_OVF_CNT_EN
        check("hold_ovf_count", {24'd0, ovf_count}, 32'd4);
`endif
        check("hold_valid_pre_ack", {31'd0, frame_valid}, 32'd1);
        ack_frame();
        check("hold_ack_valid", {31'd0, frame_valid}, 32'd0);
        tick(1);

        // ---- reset mid-frame ----
        cs = 1'b0;
        tick(2);
        send_byte(8'hC1);
        send_byte(8'hC2);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        check("midrst_valid", {31'd0, frame_valid}, 32'd0);
        check("midrst_len", {28'd0, frame_len}, 32'd0);
        check("midrst_ovf", {31'd0, overflow}, 32'd0);
        check("midrst_rd_data", {24'd0, rd_data}, 32'd0);
`ifdef SPI_FRAME_OVF_CNT_EN
        check("midrst_ovf_count", {24'd0, ovf_count}, 32'd0);
`endif
        // cs is still low: this byte belongs to the discarded frame.
        tick(2);
        send_byte(8'hEE);
        cs = 1'b1;
        tick(2);
        check("midrst_no_capture", {31'd0, frame_valid}, 32'd0);
        cs = 1'b0;
        tick(2);
        send_byte(8'hD1);
        send_byte(8'hD2);
        cs = 1'b1;
        tick(1);
        check("restart_valid", {31'd0, frame_valid}, 32'd1);
        check("restart_len", {28'd0, frame_len}, 32'd2);
        check_read("restart_rd0", 0, 8'hD1);
        check_read("restart_rd1", 1, 8'hD2);
        ack_frame();
        tick(1);

        // ---- coincident ready edge and cs rising ----
        cs = 1'b0;
        tick(2);
        send_byte(8'h5A);
        data_in = 8'h6B;
        ready   = 1'b1;
        cs      = 1'b1;
        tick(1);
        ready   = 1'b0;
        check("coin_valid", {31'd0, frame_valid}, 32'd1);
        check("coin_len", {28'd0, frame_len}, 32'd2);
        check_read("coin_rd0", 0, 8'h5A);
        check_read("coin_rd1", 1, 8'h6B);
        ack_frame();
        check("coin_ack_valid", {31'd0, frame_valid}, 32'd0);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
